// File: rtl/mem_program_loader_rom.sv
// Program memory for the RV32E core: registered fetch port with fault detection,
// plus a byte-serial loader that rewrites words at run time.
module mem_program_loader_rom #(
  parameter int          DEPTH    = 512,
  parameter int          AW       = $clog2(DEPTH),
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_ready,
  output logic          fetch_valid,
  output logic [31:0]   fetch_data,
  output logic          fetch_fault,
  input  logic          load_start,
  input  logic [AW:0]   load_len,
  input  logic [7:0]    load_byte,
  input  logic          load_byte_valid,
  output logic          load_busy,
  output logic          load_done
);

  typedef enum logic {IDLE = 1'b0, LOADING = 1'b1} state_t;

  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  state_t        state_q;
  logic          fetch_valid_q;
  logic [31:0]   fetch_data_q;
  logic          fetch_fault_q;
  logic          load_done_q;
  logic [1:0]    byte_cnt_q;
  logic [AW-1:0] word_ptr_q;
  logic [AW:0]   len_q;
  logic [23:0]   asm_q;

  // Not reset: power-on content is NOP_WORD, and loaded words survive rst_n.
  logic [31:0]   mem_q [DEPTH] = '{default: NOP_WORD};

  logic          fetch_accept;
  logic          fetch_fault_d;
  logic [AW:0]   len_d;
  logic          last_word;
  logic          mem_we;
  logic [31:0]   mem_wdata;

  always_comb begin
    fetch_accept  = fetch_req && (state_q == IDLE);
    fetch_fault_d = (|fetch_addr[1:0]) || (|fetch_addr[31:AW+2]);
    len_d         = (load_len > DEPTH_W) ? DEPTH_W : load_len;
    last_word     = (({1'b0, word_ptr_q} + (AW+1)'(1)) == len_q);
    mem_we        = (state_q == LOADING) && load_byte_valid && (byte_cnt_q == 2'd3);
    mem_wdata     = {load_byte, asm_q};
  end

  assign fetch_ready = (state_q == IDLE);
  assign load_busy   = (state_q == LOADING);
  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = fetch_data_q;
  assign fetch_fault = fetch_fault_q;
  assign load_done   = load_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= NOP_WORD;
      fetch_fault_q <= 1'b0;
      load_done_q   <= 1'b0;
      byte_cnt_q    <= 2'd0;
      word_ptr_q    <= '0;
      len_q         <= '0;
      asm_q         <= '0;
    end else begin
      fetch_valid_q <= fetch_accept;
      load_done_q   <= 1'b0;
      if (fetch_accept) begin
        fetch_fault_q <= fetch_fault_d;
        fetch_data_q  <= fetch_fault_d ? NOP_WORD : mem_q[fetch_addr[AW+1:2]];
      end
      case (state_q)
        IDLE: begin
          if (load_start) begin
            if (load_len == '0) begin
              load_done_q <= 1'b1;
            end else begin
              state_q    <= LOADING;
              len_q      <= len_d;
              word_ptr_q <= '0;
              byte_cnt_q <= 2'd0;
            end
          end
        end
        LOADING: begin
          if (load_byte_valid) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            case (byte_cnt_q)
              2'd0: asm_q[7:0]   <= load_byte;
              2'd1: asm_q[15:8]  <= load_byte;
              2'd2: asm_q[23:16] <= load_byte;
              default: begin
                word_ptr_q <= word_ptr_q + 1'b1;
                if (last_word) begin
                  state_q     <= IDLE;
                  load_done_q <= 1'b1;
                end
              end
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[word_ptr_q] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_mem_program_loader_rom.sv
// Bench for mem_program_loader_rom: scoreboarded fetches against a bench-side memory model,
// plus loader session checks (busy length, done pulses, clamping, reset mid-load).
module tb_mem_program_loader_rom;

  localparam int          DEPTH = 16;
  localparam int          AW    = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic          clk;
  logic          rst_n;
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_ready;
  logic          fetch_valid;
  logic [31:0]   fetch_data;
  logic          fetch_fault;
  logic          load_start;
  logic [AW:0]   load_len;
  logic [7:0]    load_byte;
  logic          load_byte_valid;
  logic          load_busy;
  logic          load_done;

  mem_program_loader_rom #(.DEPTH(DEPTH), .AW(AW), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_fault(fetch_fault),
    .load_start(load_start), .load_len(load_len), .load_byte(load_byte),
    .load_byte_valid(load_byte_valid), .load_busy(load_busy), .load_done(load_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [32:0] exp_q[$];
  logic [31:0] model_mem [DEPTH];
  logic [7:0]  bq[$];
  int          total;
  int          bad;
  int          busy_cnt;
  int          done_cnt;
  logic [31:0] last_data;
  logic        last_fault;

  function automatic logic [32:0] expect_of(input logic [31:0] a);
    logic f;
    f = (a[1:0] != 2'd0) || (a[31:2] >= DEPTH);
    return {f, f ? NOP : model_mem[a[AW+1:2]]};
  endfunction

  // Model of a finished (or interrupted) session: only whole words up to the clamped length land.
  task automatic model_load(input int len, input int nbytes);
    int eff;
    eff = (len > DEPTH) ? DEPTH : len;
    for (int w = 0; w < eff && (4*w + 3) < nbytes; w++)
      model_mem[w] = {bq[4*w+3], bq[4*w+2], bq[4*w+1], bq[4*w]};
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (load_busy) busy_cnt++;
      if (load_done) done_cnt++;
      total++;
      if (fetch_valid) begin
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_valid: got fault=%b data=%h, required no valid", fetch_fault, fetch_data);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          if ({fetch_fault, fetch_data} !== e) begin
            bad++;
            $display("FAIL fetch: got fault=%b data=%h, required fault=%b data=%h",
                     fetch_fault, fetch_data, e[32], e[31:0]);
          end
        end
        last_data  = fetch_data;
        last_fault = fetch_fault;
      end else if (fetch_data !== last_data || fetch_fault !== last_fault) begin
        bad++;
        $display("FAIL hold: got fault=%b data=%h, required fault=%b data=%h",
                 fetch_fault, fetch_data, last_fault, last_data);
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    exp_q.push_back(expect_of(a));
    @(negedge clk);
    fetch_req  = 1'b0;
  endtask

  task automatic start_load(input logic [AW:0] len);
    load_start = 1'b1;
    load_len   = len;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_byte       = b;
    load_byte_valid = 1'b1;
    @(negedge clk);
    load_byte_valid = 1'b0;
  endtask

  task automatic check_drained(input string name);
    idle(2);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_valid: got %0d outstanding, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_counts(input string name, input int busy_exp, input int done_exp);
    total++;
    if (busy_cnt !== busy_exp || done_cnt !== done_exp) begin
      bad++;
      $display("FAIL %s_counts: got busy=%0d done=%0d, required busy=%0d done=%0d",
               name, busy_cnt, done_cnt, busy_exp, done_exp);
    end
  endtask

  task automatic apply_reset_pulse();
    #2 rst_n = 1'b0;
    exp_q.delete();
    last_data  = NOP;
    last_fault = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    total++;
    if (fetch_ready !== 1'b1 || fetch_valid !== 1'b0 || fetch_data !== NOP ||
        fetch_fault !== 1'b0 || load_busy !== 1'b0 || load_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h flt=%b busy=%b done=%b, required 1 0 %h 0 0 0",
               fetch_ready, fetch_valid, fetch_data, fetch_fault, load_busy, load_done, NOP);
    end
    fetch_req  = 1'b1;
    fetch_addr = 32'h4;
    @(posedge clk);
    #1 rst_n = 1'b0;
    fetch_req = 1'b0;
    exp_q.delete();
    last_data  = NOP;
    last_fault = 1'b0;
    #1;
    total++;
    if (fetch_valid !== 1'b0 || fetch_data !== NOP) begin
      bad++;
      $display("FAIL reset_mid_fetch: got vld=%b data=%h, required 0 %h", fetch_valid, fetch_data, NOP);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (fetch_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b, required 1", fetch_ready);
    end
  endtask

  task automatic test_power_on();
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);
    check_drained("power_on");
  endtask

  task automatic test_load();
    busy_cnt = 0;
    done_cnt = 0;
    bq = '{8'hB7, 8'hC2, 8'hCA, 8'hF0, 8'h13, 8'h01, 8'hE1, 8'hAF};
    start_load(2);
    foreach (bq[i]) send_byte(bq[i]);
    model_load(2, 8);
    idle(2);
    check_counts("load", 8, 1);
    fetch(32'h0);
    fetch(32'h4);
    check_drained("load");
  endtask

  task automatic test_faults();
    fetch(32'h2);
    fetch(32'(4*DEPTH));
    fetch(32'(4*(DEPTH-1)));
    fetch(32'h1);
    fetch(32'hFFFF_FFFC);
    fetch(32'h8000_0000);
    check_drained("faults");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) fetch(32'($urandom_range(0, 4*DEPTH + 7)));
    check_drained("back_to_back");
  endtask

  task automatic test_edges();
    busy_cnt = 0;
    done_cnt = 0;
    start_load(0);
    idle(2);
    check_counts("len_zero", 0, 1);

    busy_cnt = 0;
    done_cnt = 0;
    bq.delete();
    for (int i = 0; i < 4*(DEPTH+5); i++) bq.push_back(8'($urandom_range(0, 255)));
    start_load((AW+1)'(DEPTH + 5));
    foreach (bq[i]) send_byte(bq[i]);
    model_load(DEPTH + 5, bq.size());
    idle(2);
    check_counts("clamp", 4*DEPTH, 1);
    for (int w = 0; w < DEPTH; w++) fetch(32'(4*w));
    fetch(32'(4*DEPTH));
    check_drained("clamp");

    busy_cnt = 0;
    done_cnt = 0;
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    start_load(2);
    for (int i = 0; i < 3; i++) send_byte(bq[i]);
    load_start = 1'b1;
    load_len   = 1;
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    total++;
    if (fetch_ready !== 1'b0 || load_busy !== 1'b1) begin
      bad++;
      $display("FAIL loading_ready: got rdy=%b busy=%b, required 0 1", fetch_ready, load_busy);
    end
    @(negedge clk);
    load_start = 1'b0;
    fetch_req  = 1'b0;
    for (int i = 3; i < 8; i++) send_byte(bq[i]);
    model_load(2, 8);
    idle(2);
    check_counts("start_while_loading", 9, 1);
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);
    check_drained("start_while_loading");
  endtask

  task automatic test_reset_mid_load();
    busy_cnt = 0;
    done_cnt = 0;
    bq = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h99, 8'hAA};
    start_load(2);
    foreach (bq[i]) send_byte(bq[i]);
    model_load(2, 6);
    apply_reset_pulse();
    @(negedge clk);
    total++;
    if (fetch_ready !== 1'b1 || load_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_load_state: got rdy=%b busy=%b, required 1 0", fetch_ready, load_busy);
    end
    fetch(32'h0);
    fetch(32'h4);
    check_drained("reset_mid_load");
    check_counts("reset_mid_load", 7, 0);

    bq = '{8'h01, 8'h02, 8'h03, 8'h04};
    start_load(1);
    foreach (bq[i]) send_byte(bq[i]);
    model_load(1, 4);
    idle(1);
    fetch(32'h0);
    fetch(32'h4);
    check_drained("after_reset_load");
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    busy_cnt        = 0;
    done_cnt        = 0;
    last_data       = NOP;
    last_fault      = 1'b0;
    foreach (model_mem[i]) model_mem[i] = NOP;
    rst_n           = 1'b0;
    fetch_req       = 1'b0;
    fetch_addr      = 32'h0;
    load_start      = 1'b0;
    load_len        = '0;
    load_byte       = 8'h00;
    load_byte_valid = 1'b0;
    idle(2);
    #2 rst_n = 1'b1;
    @(negedge clk);

    test_reset();
    test_power_on();
    test_load();
    test_faults();
    test_back_to_back();
    test_edges();
    test_reset_mid_load();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
